microcode_sequencer: RTL

//  Reader side of the 64x34 microcode ROM: owns the micro-PC, fetches one

---
 rtl/microcode_pkg.sv | 54 +++++
 rtl/uinstr_decode.sv | 44 ++++
 rtl/microcode_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode sequencer: microinstruction field
// positions, ALU operation encodings, the decoded control bundle and the
// sequencer FSM states.
package microcode_pkg;

  // Bit positions of each field within a 34-bit microinstruction
  localparam int MEM_ADDR_MSB = 33;
  localparam int MEM_ADDR_LSB = 26;
  localparam int RA_MSB       = 25;
  localparam int RA_LSB       = 22;
  localparam int RB_MSB       = 21;
  localparam int RB_LSB       = 18;
  localparam int RD_MSB       = 17;
  localparam int RD_LSB       = 14;
  localparam int REG_WE_BIT   = 13;
  localparam int IMM_SEL_BIT  = 12;
  localparam int MEM_WE_BIT   = 11;
  localparam int ALU_OP_MSB   = 10;
  localparam int ALU_OP_LSB   = 8;
  localparam int IMM_MSB      = 7;
  localparam int IMM_LSB      = 0;

  // ALU operation encodings carried in the alu_op field
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Decoded datapath control fields, in microinstruction word order
  typedef struct packed {
    logic [7:0] mem_addr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rd;
    logic       reg_we;
    logic       imm_sel;
    logic       mem_we;
    logic [2:0] alu_op;
    logic [7:0] imm;
  } uctrl_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/uinstr_decode.sv
// Combinational microinstruction decoder. Splits the instruction register
// into datapath control fields and scrubs the ROM don't-care bits so the
// datapath only ever sees deterministic values. All fields are zero while
// the instruction is not valid.
module uinstr_decode
  import microcode_pkg::*;
#(
  parameter int WORD_W = 34
) (
  input  logic [WORD_W-1:0] ir,
  input  logic              valid,
  output uctrl_t            ctrl
);

  // Field extraction plus scrub of operands the instruction does not use
  always_comb begin
    ctrl = '0;
    if (valid) begin
      ctrl.ra      = ir[RA_MSB:RA_LSB];
      ctrl.rd      = ir[RD_MSB:RD_LSB];
      ctrl.reg_we  = ir[REG_WE_BIT];
      ctrl.imm_sel = ir[IMM_SEL_BIT];
      ctrl.mem_we  = ir[MEM_WE_BIT];
      if (ir[IMM_SEL_BIT]) begin
        // Immediate operand: rb and alu_op are don't-cares in the ROM
        ctrl.rb     = 4'd0;
        ctrl.alu_op = ALU_ADD;
        ctrl.imm    = ir[IMM_MSB:IMM_LSB];
      end else begin
        ctrl.rb     = ir[RB_MSB:RB_LSB];
        ctrl.alu_op = ir[ALU_OP_MSB:ALU_OP_LSB];
        ctrl.imm    = 8'd0;
      end
      if (ir[MEM_WE_BIT]) begin
        ctrl.mem_addr = ir[MEM_ADDR_MSB:MEM_ADDR_LSB];
      end else begin
        ctrl.mem_addr = 8'd0;
      end
    end else begin
      ctrl = '0;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Reader side of the 64x34 microcode ROM. Owns the micro-PC, fetches one
// microinstruction per step into the instruction register, and presents the
// decoded fields to the datapath until it accepts them. Outputs depend only
// on registered state, never combinationally on rom_data.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              ctrl_valid,
  input  logic              dp_ready,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [3:0]        rd,
  output logic              reg_we,
  output logic              imm_sel,
  output logic              mem_we,
  output logic [2:0]        alu_op,
  output logic [7:0]        imm,
  output logic [7:0]        mem_addr,
  output logic              busy,
  output logic              done
);

  seq_state_e          state_r;
  seq_state_e          state_nx_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   end_q_r;
  logic [WORD_W-1:0]   ir_r;
  logic                handshake_s;
  logic                last_s;
  uctrl_t              ctrl_s;

  assign handshake_s = (state_r == EXEC) && dp_ready;
  assign last_s      = (pc_r == end_q_r);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; abort overrides both start and the handshake
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (start) begin
          state_nx_s = FETCH;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = EXEC;
        end
      end
      EXEC: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (handshake_s) begin
          state_nx_s = last_s ? DONE : FETCH;
        end else begin
          state_nx_s = EXEC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Micro-PC, program end bound and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= {ADDR_W{1'b0}};
      end_q_r <= {ADDR_W{1'b0}};
      ir_r    <= {WORD_W{1'b0}};
    end else if (abort) begin
      pc_r    <= pc_r;
      end_q_r <= end_q_r;
      ir_r    <= ir_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            pc_r    <= {ADDR_W{1'b0}};
            end_q_r <= end_addr;
          end else begin
            pc_r    <= pc_r;
            end_q_r <= end_q_r;
          end
        end
        FETCH: ir_r <= rom_data;
        EXEC: begin
          // The end bound is reached before pc could pass the top address
          if (handshake_s && !last_s) begin
            pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          pc_r    <= pc_r;
          end_q_r <= end_q_r;
          ir_r    <= ir_r;
        end
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    ctrl_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      IDLE:  begin ctrl_valid = 1'b0; busy = 1'b0; done = 1'b0; end
      FETCH: begin ctrl_valid = 1'b0; busy = 1'b1; done = 1'b0; end
      EXEC:  begin ctrl_valid = 1'b1; busy = 1'b1; done = 1'b0; end
      DONE:  begin ctrl_valid = 1'b0; busy = 1'b0; done = 1'b1; end
      default: begin ctrl_valid = 1'b0; busy = 1'b0; done = 1'b0; end
    endcase
  end

  assign rom_addr = pc_r;

  uinstr_decode #(
    .WORD_W (WORD_W)
  ) u_decode (
    .ir    (ir_r),
    .valid (ctrl_valid),
    .ctrl  (ctrl_s)
  );

  assign mem_addr = ctrl_s.mem_addr;
  assign ra       = ctrl_s.ra;
  assign rb       = ctrl_s.rb;
  assign rd       = ctrl_s.rd;
  assign reg_we   = ctrl_s.reg_we;
  assign imm_sel  = ctrl_s.imm_sel;
  assign mem_we   = ctrl_s.mem_we;
  assign alu_op   = ctrl_s.alu_op;
  assign imm      = ctrl_s.imm;

endmodule
